// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM splitter with programmable dead band.
// A single-ended PWM is split into high-side and low-side drives. Every
// change of the commanded level passes through a dead band of
// i_dead_time+1 cycles, so both drives are never active together. A
// PWM glitch shorter than the dead band restarts the band and never
// reaches a drive pin. All pins come straight from flops.
module pwm_deadtime_gen #(
  parameter int DT_W    = 8,
  parameter int OUT_INV = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_pwm,
  input  logic [DT_W-1:0] i_dead_time,
  output logic            o_pwm_h,
  output logic            o_pwm_l,
  output logic            o_dead
);

  // Pin polarity: the inversion is folded into the value loaded into the
  // output flops, so the pins stay glitch-free and purely registered.
  localparam logic INV = (OUT_INV != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            target_q, target_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            pwm_q, pwm_d;
  logic            h_pin_q, h_pin_d;
  logic            l_pin_q, l_pin_d;
  logic            dead_q, dead_d;

  // Input sampling: every decision below looks only at the registered PWM.
  always_comb begin
    pwm_d = i_pwm;
  end

  // Next-state logic: dead-band entry, restart on target change, expiry.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (!i_en) begin
      // Disable overrides every other transition.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = DEAD;
          target_d = pwm_q;
          cnt_d    = i_dead_time;
        end
        HIGH: begin
          if (!pwm_q) begin
            state_d  = DEAD;
            target_d = 1'b0;
            cnt_d    = i_dead_time;
          end
        end
        LOW: begin
          if (pwm_q) begin
            state_d  = DEAD;
            target_d = 1'b1;
            cnt_d    = i_dead_time;
          end
        end
        DEAD: begin
          if (pwm_q != target_q) begin
            // Restart wins over expiry so short glitches are swallowed.
            target_d = pwm_q;
            cnt_d    = i_dead_time;
          end else if (cnt_q == '0) begin
            state_d = target_q ? HIGH : LOW;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output decode of the next state, so pins change on the same edge as the state.
  always_comb begin
    h_pin_d = (state_d == HIGH) ^ INV;
    l_pin_d = (state_d == LOW)  ^ INV;
    dead_d  = (state_d == DEAD);
  end

  // State, counter, sampled PWM and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      cnt_q    <= '0;
      pwm_q    <= 1'b0;
      h_pin_q  <= INV;
      l_pin_q  <= INV;
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      h_pin_q  <= h_pin_d;
      l_pin_q  <= l_pin_d;
      dead_q   <= dead_d;
    end
  end

  assign o_pwm_h = h_pin_q;
  assign o_pwm_l = l_pin_q;
  assign o_dead  = dead_q;

endmodule
